// File: rtl/fp32_rx_operand_packer_if.sv
// Operand bus between the UART receiver, the FP32 operand packer and the MAC.
// The slave modport is the packer's view; the master modport is the view of
// whatever drives the byte stream and consumes the operand set.
interface fp32_rx_operand_packer_if;
    logic [7:0]  RX_DATA_I;
    logic        RX_VALID_I;
    logic        MAC_READY_I;
    logic [31:0] ALPHA_O;
    logic [31:0] BRAVO_O;
    logic [31:0] ACC_O;
    logic        MAC_VALID_O;

    modport slave (
        input  RX_DATA_I,
        input  RX_VALID_I,
        input  MAC_READY_I,
        output ALPHA_O,
        output BRAVO_O,
        output ACC_O,
        output MAC_VALID_O
    );

    modport master (
        output RX_DATA_I,
        output RX_VALID_I,
        output MAC_READY_I,
        input  ALPHA_O,
        input  BRAVO_O,
        input  ACC_O,
        input  MAC_VALID_O
    );
endinterface

// File: rtl/fp32_rx_operand_packer.sv
// FP32 operand packer: collects a 12-byte UART frame (alpha, bravo, acc, each
// MSB first) into three FP32 words and offers them to the MAC over a
// valid/ready handshake. Partial frames are dropped after an inter-byte
// timeout; bytes arriving while a set is still pending are dropped and flagged.
//
// Optional feature: define FP32_PACKER_SYNC_EN to require a SYNC_BYTE header
// in front of every frame. Without it the first byte seen while idle is
// alpha[31:24].
module fp32_rx_operand_packer #(
    parameter int TIMEOUT_CLKS = 104160
`ifdef FP32_PACKER_SYNC_EN
    ,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
`endif
) (
    input  logic                     CLK_I,
    input  logic                     RSTL_I,
    fp32_rx_operand_packer_if.slave  pk,
    input  logic                     ERR_CLR_I,
    output logic                     OVERRUN_O,
    output logic                     TIMEOUT_O
);

    // Width of the inter-byte timeout counter; it only has to reach TIMEOUT_CLKS-1.
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [3:0]    LAST_IDX = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    // Write one received byte into the 96-bit assembly image. Byte k lands in
    // word k/4, lane 3-(k%4), i.e. bit position 95-8k downward.
    function automatic logic [95:0] put_byte(input logic [95:0] frame,
                                             input logic [3:0]  idx,
                                             input logic [7:0]  data);
        logic [95:0] res;
        res = frame;
        for (int i = 0; i < 12; i++) begin
            if (idx == 4'(i)) begin
                res[95 - 8*i -: 8] = data;
            end else begin
                res[95 - 8*i -: 8] = frame[95 - 8*i -: 8];
            end
        end
        return res;
    endfunction

    state_t         state_r,    state_nxt_s;
    logic [3:0]     byte_cnt_r, byte_cnt_nxt_s;
    logic [TW-1:0]  tmo_cnt_r,  tmo_cnt_nxt_s;
    logic [95:0]    asm_r,      asm_nxt_s;
    logic [31:0]    alpha_r,    alpha_nxt_s;
    logic [31:0]    bravo_r,    bravo_nxt_s;
    logic [31:0]    acc_r,      acc_nxt_s;
    logic           valid_r,    valid_nxt_s;
    logic           overrun_r,  overrun_nxt_s;
    logic           timeout_r,  timeout_nxt_s;
    logic           ovr_set_s;
    logic           tmo_set_s;

    // What an idle packer does with the byte on the bus: whether it starts a
    // frame, which byte count it starts from and the resulting assembly image.
    logic           idle_take_s;
    logic [3:0]     start_cnt_s;
    logic [95:0]    asm_start_s;

`ifdef FP32_PACKER_SYNC_EN
    // Only the header opens a frame; it is consumed, not stored.
    assign idle_take_s = pk.RX_VALID_I && (pk.RX_DATA_I == SYNC_BYTE);
    assign start_cnt_s = 4'd0;
    assign asm_start_s = asm_r;
`else
    // Any byte opens a frame and is itself alpha[31:24].
    assign idle_take_s = pk.RX_VALID_I;
    assign start_cnt_s = 4'd1;
    assign asm_start_s = put_byte(asm_r, 4'd0, pk.RX_DATA_I);
`endif

    // Next-state, datapath and flag-event decode for the IDLE/COLLECT/HOLD FSM.
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        tmo_cnt_nxt_s  = tmo_cnt_r;
        asm_nxt_s      = asm_r;
        alpha_nxt_s    = alpha_r;
        bravo_nxt_s    = bravo_r;
        acc_nxt_s      = acc_r;
        valid_nxt_s    = valid_r;
        ovr_set_s      = 1'b0;
        tmo_set_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tmo_cnt_nxt_s = TMO_ZERO;
                if (idle_take_s) begin
                    asm_nxt_s      = asm_start_s;
                    byte_cnt_nxt_s = start_cnt_s;
                    state_nxt_s    = ST_COLLECT;
                end else begin
                    byte_cnt_nxt_s = 4'd0;
                end
            end

            ST_COLLECT: begin
                if (pk.RX_VALID_I) begin
                    // A byte always beats a timeout landing in the same cycle.
                    asm_nxt_s     = put_byte(asm_r, byte_cnt_r, pk.RX_DATA_I);
                    tmo_cnt_nxt_s = TMO_ZERO;
                    if (byte_cnt_r == LAST_IDX) begin
                        alpha_nxt_s    = asm_nxt_s[95:64];
                        bravo_nxt_s    = asm_nxt_s[63:32];
                        acc_nxt_s      = asm_nxt_s[31:0];
                        valid_nxt_s    = 1'b1;
                        byte_cnt_nxt_s = 4'd0;
                        state_nxt_s    = ST_HOLD;
                    end else begin
                        byte_cnt_nxt_s = byte_cnt_r + 4'd1;
                    end
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_cnt_nxt_s  = TMO_ZERO;
                    byte_cnt_nxt_s = 4'd0;
                    tmo_set_s      = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    tmo_cnt_nxt_s = tmo_cnt_r + TMO_ONE;
                end
            end

            ST_HOLD: begin
                tmo_cnt_nxt_s = TMO_ZERO;
                if (valid_r && pk.MAC_READY_I) begin
                    // Transfer cycle: valid drops next cycle, giving the MAC a
                    // low phase before any later set; a byte here opens the
                    // next frame exactly as it would in IDLE.
                    valid_nxt_s = 1'b0;
                    if (idle_take_s) begin
                        asm_nxt_s      = asm_start_s;
                        byte_cnt_nxt_s = start_cnt_s;
                        state_nxt_s    = ST_COLLECT;
                    end else begin
                        byte_cnt_nxt_s = 4'd0;
                        state_nxt_s    = ST_IDLE;
                    end
                end else if (pk.RX_VALID_I) begin
                    ovr_set_s = 1'b1;
                end else begin
                    ovr_set_s = 1'b0;
                end
            end

            default: begin
                state_nxt_s    = ST_IDLE;
                byte_cnt_nxt_s = 4'd0;
                tmo_cnt_nxt_s  = TMO_ZERO;
                valid_nxt_s    = 1'b0;
            end
        endcase
    end

    // Sticky error flags: a new event takes priority over a clear request.
    always_comb begin
        if (ovr_set_s) begin
            overrun_nxt_s = 1'b1;
        end else if (ERR_CLR_I) begin
            overrun_nxt_s = 1'b0;
        end else begin
            overrun_nxt_s = overrun_r;
        end

        if (tmo_set_s) begin
            timeout_nxt_s = 1'b1;
        end else if (ERR_CLR_I) begin
            timeout_nxt_s = 1'b0;
        end else begin
            timeout_nxt_s = timeout_r;
        end
    end

    // State, counters, assembly image, operand outputs and flags.
    always_ff @(posedge CLK_I or negedge RSTL_I) begin
        if (!RSTL_I) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 4'd0;
            tmo_cnt_r  <= TMO_ZERO;
            asm_r      <= 96'd0;
            alpha_r    <= 32'd0;
            bravo_r    <= 32'd0;
            acc_r      <= 32'd0;
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            tmo_cnt_r  <= tmo_cnt_nxt_s;
            asm_r      <= asm_nxt_s;
            alpha_r    <= alpha_nxt_s;
            bravo_r    <= bravo_nxt_s;
            acc_r      <= acc_nxt_s;
            valid_r    <= valid_nxt_s;
            overrun_r  <= overrun_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign pk.ALPHA_O     = alpha_r;
    assign pk.BRAVO_O     = bravo_r;
    assign pk.ACC_O       = acc_r;
    assign pk.MAC_VALID_O = valid_r;
    assign OVERRUN_O      = overrun_r;
    assign TIMEOUT_O      = timeout_r;

endmodule

// File: tb/tb_fp32_rx_operand_packer.sv
// Self-checking bench for fp32_rx_operand_packer. A byte-queue model of the
// frame rules is compared against every output on every falling edge, and
// hand-computed literal expectations pin the model at key points.
module tb_fp32_rx_operand_packer;

    localparam int TB_TMO = 40;

    logic clk;
    logic rst_n;
    logic err_clr;
    logic ovr;
    logic tmo;

    int n_checks = 0;
    int n_fail   = 0;

    fp32_rx_operand_packer_if bus ();

    fp32_rx_operand_packer #(.TIMEOUT_CLKS(TB_TMO)) dut (
        .CLK_I     (clk),
        .RSTL_I    (rst_n),
        .pk        (bus),
        .ERR_CLR_I (err_clr),
        .OVERRUN_O (ovr),
        .TIMEOUT_O (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  q[$];
    bit          m_collect = 1'b0;
    int          m_gap     = 0;
    logic [31:0] m_alpha   = 32'd0;
    logic [31:0] m_bravo   = 32'd0;
    logic [31:0] m_acc     = 32'd0;
    bit          m_valid   = 1'b0;
    bit          m_ovr     = 1'b0;
    bit          m_tmo     = 1'b0;

    task automatic m_clear();
        q.delete();
        m_collect = 1'b0;
        m_gap     = 0;
        m_alpha   = 32'd0;
        m_bravo   = 32'd0;
        m_acc     = 32'd0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_tmo     = 1'b0;
    endtask

    task automatic m_step();
        bit rxv, rdy, clr, so, st;
        logic [7:0] d;
        rxv = bus.RX_VALID_I;
        rdy = bus.MAC_READY_I;
        clr = err_clr;
        d   = bus.RX_DATA_I;
        so  = 1'b0;
        st  = 1'b0;
        if (m_valid && !rdy) begin
            if (rxv) so = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (rxv) begin
                if (!m_collect) begin
`ifdef FP32_PACKER_SYNC_EN
                    if (d == 8'hA5) begin
                        m_collect = 1'b1;
                        q.delete();
                    end
`else
                    m_collect = 1'b1;
                    q.delete();
                    q.push_back(d);
`endif
                end else begin
                    q.push_back(d);
                end
                m_gap = 0;
                if (m_collect && q.size() == 12) begin
                    m_alpha   = {q[0], q[1], q[2], q[3]};
                    m_bravo   = {q[4], q[5], q[6], q[7]};
                    m_acc     = {q[8], q[9], q[10], q[11]};
                    m_valid   = 1'b1;
                    m_collect = 1'b0;
                    q.delete();
                end
            end else if (m_collect) begin
                if (m_gap == TB_TMO - 1) begin
                    m_collect = 1'b0;
                    q.delete();
                    st = 1'b1;
                end else begin
                    m_gap++;
                end
            end
        end
        if (so) m_ovr = 1'b1; else if (clr) m_ovr = 1'b0;
        if (st) m_tmo = 1'b1; else if (clr) m_tmo = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_clear();
            else m_step();
        end
    end

    // Every falling edge: all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("alpha",   bus.ALPHA_O, m_alpha);
            check("bravo",   bus.BRAVO_O, m_bravo);
            check("acc",     bus.ACC_O,   m_acc);
            check("valid",   {31'd0, bus.MAC_VALID_O}, {31'd0, m_valid});
            check("overrun", {31'd0, ovr}, {31'd0, m_ovr});
            check("timeout", {31'd0, tmo}, {31'd0, m_tmo});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.RX_DATA_I  = d;
        bus.RX_VALID_I = 1'b1;
        @(negedge clk);
        bus.RX_VALID_I = 1'b0;
        bus.RX_DATA_I  = 8'd0;
    endtask

    task automatic send_hdr();
`ifdef FP32_PACKER_SYNC_EN
        send_byte(8'hA5);
`endif
    endtask

    task automatic send_range(input logic [95:0] f, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(f[95 - 8*i -: 8]);
    endtask

    // Full frame; optional idle gap of gap_len clocks before byte gap_at.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input int gap_at, input int gap_len);
        logic [95:0] f;
        f = {a, b, c};
        send_hdr();
        for (int i = 0; i < 12; i++) begin
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            if (i == 11) begin
                bus.RX_DATA_I  = f[7:0];
                bus.RX_VALID_I = 1'b1;
                check("valid_before_last", {31'd0, bus.MAC_VALID_O}, 32'd0);
                @(negedge clk);
                bus.RX_VALID_I = 1'b0;
                bus.RX_DATA_I  = 8'd0;
            end else begin
                send_byte(f[95 - 8*i -: 8]);
            end
        end
    endtask

    task automatic expect_set(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        check({tag, "_valid"}, {31'd0, bus.MAC_VALID_O}, 32'd1);
        check({tag, "_alpha"}, bus.ALPHA_O, a);
        check({tag, "_bravo"}, bus.BRAVO_O, b);
        check({tag, "_acc"},   bus.ACC_O,   c);
    endtask

    task automatic xfer();
        bus.MAC_READY_I = 1'b1;
        tick();
        bus.MAC_READY_I = 1'b0;
        check("valid_after_xfer", {31'd0, bus.MAC_VALID_O}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n           = 1'b0;
        err_clr         = 1'b0;
        bus.RX_DATA_I   = 8'd0;
        bus.RX_VALID_I  = 1'b0;
        bus.MAC_READY_I = 1'b0;
        repeat (3) tick();
        check("rst_alpha", bus.ALPHA_O, 32'd0);
        check("rst_valid", {31'd0, bus.MAC_VALID_O}, 32'd0);
        check("rst_flags", {30'd0, ovr, tmo}, 32'd0);
        rst_n = 1'b1;
        tick();

        // First set, MAC not ready: valid 1 clk after the 12th strobe, then held.
        send_frame(32'hBF000000, 32'h3F400000, 32'h00000000, 0, 0);
        expect_set("f1", 32'hBF000000, 32'h3F400000, 32'h00000000);
        repeat (5) tick();
        expect_set("f1_hold", 32'hBF000000, 32'h3F400000, 32'h00000000);

        // Transfer, then a second set.
        xfer();
        send_frame(32'h3F000000, 32'h3EE00000, 32'h00000000, 0, 0);
        expect_set("f2", 32'h3F000000, 32'h3EE00000, 32'h00000000);
        xfer();

        // Partial frame of 5 bytes times out exactly TB_TMO clocks after its last byte.
        send_hdr();
        send_range({32'h11223344, 32'h55667788, 32'h99AABBCC}, 0, 4);
        repeat (TB_TMO - 1) tick();
        check("tmo_not_yet", {31'd0, tmo}, 32'd0);
        tick();
        check("tmo_set", {31'd0, tmo}, 32'd1);
        check("tmo_no_valid", {31'd0, bus.MAC_VALID_O}, 32'd0);
        send_frame(32'h40490FDB, 32'h402DF854, 32'h3F800000, 0, 0);
        expect_set("f3", 32'h40490FDB, 32'h402DF854, 32'h3F800000);

        // Bytes during HOLD are dropped and flagged.
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("ovr_set", {31'd0, ovr}, 32'd1);
        expect_set("f3_kept", 32'h40490FDB, 32'h402DF854, 32'h3F800000);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clr", {31'd0, ovr}, 32'd0);
        check("tmo_clr", {31'd0, tmo}, 32'd0);
        // A set event coinciding with a clear wins.
        err_clr = 1'b1;
        send_byte(8'hCC);
        err_clr = 1'b0;
        check("ovr_set_wins", {31'd0, ovr}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovr_clr2", {31'd0, ovr}, 32'd0);

`ifndef FP32_PACKER_SYNC_EN
        // Byte in the transfer cycle becomes byte 0 of the next frame.
        bus.MAC_READY_I = 1'b1;
        bus.RX_VALID_I  = 1'b1;
        bus.RX_DATA_I   = 8'h41;
        tick();
        bus.MAC_READY_I = 1'b0;
        bus.RX_VALID_I  = 1'b0;
        bus.RX_DATA_I   = 8'd0;
        check("xfer_byte_valid", {31'd0, bus.MAC_VALID_O}, 32'd0);
        check("xfer_byte_no_ovr", {31'd0, ovr}, 32'd0);
        send_range({32'h41490FDB, 32'h402DF854, 32'h3F800000}, 1, 11);
        expect_set("f4", 32'h41490FDB, 32'h402DF854, 32'h3F800000);
        xfer();
`else
        // Header in the transfer cycle opens the next frame.
        bus.MAC_READY_I = 1'b1;
        bus.RX_VALID_I  = 1'b1;
        bus.RX_DATA_I   = 8'hA5;
        tick();
        bus.MAC_READY_I = 1'b0;
        bus.RX_VALID_I  = 1'b0;
        bus.RX_DATA_I   = 8'd0;
        check("xfer_hdr_no_ovr", {31'd0, ovr}, 32'd0);
        send_range({32'h41490FDB, 32'h402DF854, 32'h3F800000}, 0, 11);
        expect_set("f4", 32'h41490FDB, 32'h402DF854, 32'h3F800000);
        xfer();
`endif

        // A byte arriving exactly on the timeout cycle wins.
        send_frame(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 3, TB_TMO - 1);
        expect_set("f5", 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C);
        check("f5_no_tmo", {31'd0, tmo}, 32'd0);
        xfer();

        // MAC_READY_I while nothing is pending does nothing.
        bus.MAC_READY_I = 1'b1;
        repeat (3) tick();
        bus.MAC_READY_I = 1'b0;
        check("ready_idle", {31'd0, bus.MAC_VALID_O}, 32'd0);

        // Reset mid-frame: immediate return to zero, no flag.
        send_hdr();
        send_range({32'hC0000000, 32'h40000000, 32'hBF800000}, 0, 5);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_alpha", bus.ALPHA_O, 32'd0);
        check("rst_mid_bravo", bus.BRAVO_O, 32'd0);
        check("rst_mid_flags", {30'd0, ovr, tmo}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_frame(32'hC0000000, 32'h40000000, 32'hBF800000, 0, 0);
        expect_set("f6", 32'hC0000000, 32'h40000000, 32'hBF800000);

        // Reset while holding a set.
        #3 rst_n = 1'b0;
        #1;
        check("rst_hold_valid", {31'd0, bus.MAC_VALID_O}, 32'd0);
        check("rst_hold_acc", bus.ACC_O, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef FP32_PACKER_SYNC_EN
        // Non-header bytes in IDLE are ignored without any flag.
        send_byte(8'h00);
        send_byte(8'h12);
        repeat (TB_TMO + 5) tick();
        check("sync_ignore_tmo", {31'd0, tmo}, 32'd0);
        check("sync_ignore_valid", {31'd0, bus.MAC_VALID_O}, 32'd0);
        send_frame(32'h3F800000, 32'h40400000, 32'h40A00000, 0, 0);
        expect_set("f7", 32'h3F800000, 32'h40400000, 32'h40A00000);
        xfer();
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_rx_operand_packer.md
Name: fp32_rx_operand_packer

Overview:
- Sits directly upstream of the FP32 MAC in the rx→mac→tx path.
- Takes a stream of bytes from the UART receiver and packs them into three FP32 words: alpha, bravo and acc.
- Presents the packed operand set to the MAC through a valid/ready handshake.
- Discards partial frames after an inter-byte timeout and flags bytes lost while a set is pending.

Parameters:
- TIMEOUT_CLKS, 104160: clocks allowed between bytes inside one frame (20 bit-times at 5208 clk/bit) before the partial frame is discarded.
- SYNC_BYTE, 8'hA5: frame header value, used only when FP32_PACKER_SYNC_EN is defined.

Ports:
- CLK_I  in  1  system clock.
- RSTL_I  in  1  asynchronous active-low reset.
- RX_DATA_I  in  8  received byte; valid only while RX_VALID_I=1.
- RX_VALID_I  in  1  one-cycle strobe per received byte.
- MAC_READY_I  in  1  MAC can accept an operand set (MAC idle).
- ERR_CLR_I  in  1  synchronous clear of the sticky error flags.
- ALPHA_O  out  32  packed multiplicand.
- BRAVO_O  out  32  packed multiplier.
- ACC_O  out  32  packed accumulator addend.
- MAC_VALID_O  out  1  operand set valid.
- OVERRUN_O  out  1  sticky: a byte was dropped while in HOLD.
- TIMEOUT_O  out  1  sticky: a partial frame was discarded.

Behaviour:
- Reset (asynchronous, RSTL_I=0): all outputs 0, state=IDLE, byte_cnt=0, timeout counter=0, assembly registers=0.
- Frame format: 12 bytes, in the order alpha[31:24], alpha[23:16], …, alpha[7:0], then bravo MSB-first, then acc MSB-first.
- Assembly: byte k (0..11) is written into assembly word k/4, byte lane 3-(k%4). Separate assembly registers are used, so ALPHA_O/BRAVO_O/ACC_O change only on frame completion.
- IDLE:
  - Timeout counter held at 0.
  - On RX_VALID_I, the byte is stored as byte 0, byte_cnt=1, next state COLLECT.
- COLLECT:
  - The timeout counter increments every cycle without RX_VALID_I and clears to 0 on each byte.
  - On each RX_VALID_I, store the byte and increment byte_cnt.
  - When byte 11 is accepted in cycle N, copy the assembly registers to the outputs, set MAC_VALID_O=1 at N+1 and go to HOLD. Latency is 1 clock from the last byte strobe.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte: discard the frame, set byte_cnt=0 and TIMEOUT_O=1, and go to IDLE.
  - A byte and the timeout in the same cycle: the byte wins and the counter clears.
- HOLD:
  - MAC_VALID_O=1 with the outputs stable.
  - Transfer happens in a cycle with MAC_VALID_O & MAC_READY_I. In the following cycle MAC_VALID_O=0 and the state is IDLE, so MAC_VALID_O is always low for at least 1 cycle between sets (required by the MAC's edge-triggered start).
  - RX_VALID_I in HOLD with no transfer that cycle: the byte is dropped and OVERRUN_O=1.
  - RX_VALID_I in the transfer cycle: the byte is processed as an IDLE byte, i.e. it becomes byte 0 of the next frame, with no overrun.
- MAC_READY_I while MAC_VALID_O=0 has no effect.
- ERR_CLR_I clears OVERRUN_O and TIMEOUT_O next cycle. If a set-event coincides with ERR_CLR_I, the set wins.
- Reset asserted mid-frame or in HOLD: immediate return to the reset values. The partial or pending set is lost and no flag is raised.
- byte_cnt is 4 bits and never exceeds 11; there is no wrap-around path.

Optional Feature:
- Macro FP32_PACKER_SYNC_EN.
- Defined:
  - In IDLE, only RX_DATA_I==SYNC_BYTE is accepted. It moves the state to COLLECT with byte_cnt=0 and is not stored.
  - Any other byte in IDLE is silently ignored; no flag is raised.
  - The frame is 13 bytes on the wire, and the timeout applies from the header onward.
- Not defined: no header. The first byte received in IDLE is alpha[31:24].

Test Plan:
- Reset, then send 12 bytes BF 00 00 00 3F 40 00 00 00 00 00 00 with MAC_READY_I=0: MAC_VALID_O=1 exactly 1 clk after the 12th strobe, ALPHA_O=BF000000, BRAVO_O=3F400000, ACC_O=00000000, and they stay high and stable.
- Then raise MAC_READY_I for one cycle: MAC_VALID_O falls the next cycle. Send 3F000000/3EE00000/00000000: a new valid rises and the outputs are updated.
- Send 5 bytes, then idle for TIMEOUT_CLKS clocks: TIMEOUT_O=1, MAC_VALID_O stays 0. A following full 12-byte frame is assembled correctly from its first byte.
- Complete a frame and hold MAC_READY_I=0, then strobe 2 bytes: OVERRUN_O=1 and the outputs are unchanged. Pulse ERR_CLR_I: OVERRUN_O=0.
- In HOLD, assert MAC_READY_I and RX_VALID_I (data 0x41) in the same cycle: no overrun, and the next completed frame has ALPHA_O[31:24]=0x41.
- With FP32_PACKER_SYNC_EN: bytes 00 12 are ignored, then A5 plus 12 data bytes gives the correct operands. Also drop RSTL_I after 6 bytes: all outputs read 0 immediately, and a fresh frame after release assembles correctly.
